// File: rtl/ic_fill_unit.sv
// Instruction-cache tag/valid lookup and line-fill controller.
// Direct-mapped tags; a miss stalls fetch, fetches one 128-bit line and installs it.
module ic_fill_unit #(
  parameter int IWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:2]       pc_if,
  input  logic              ic_flush,
  output logic              ic_req,
  output logic [31:4]       ic_req_adr,
  input  logic              ic_req_ack,
  input  logic              ic_rdat_m_valid,
  output logic [IWIDTH-3:0] ic_ram_wadr_all,
  output logic              ic_stall,
  output logic              ic_stall_dly,
  output logic              ic_stall_fin,
  output logic              ic_stall_fin2,
  output logic              ic_flush_busy
);

  localparam int IDX_W = IWIDTH - 2;
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IWIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FIN,
    S_FLUSH
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];
  logic [31:4]      r_line;
  logic [IDX_W-1:0] r_cnt;
  logic             r_flush_pend;
  logic             r_stall_dly;
  logic             r_stall_fin2;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_capture;
  logic             w_fill;
  logic             w_unused;

  assign w_idx    = pc_if[IWIDTH+1:4];
  assign w_tag    = pc_if[31:IWIDTH+2];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused = &{1'b0, pc_if[3:2]};

  always_comb begin
    w_next    = r_state;
    ic_stall  = 1'b1;
    ic_req    = 1'b0;
    w_capture = 1'b0;
    w_fill    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ic_flush || r_flush_pend) begin
          w_next = S_FLUSH;
        end else if (!w_hit) begin
          w_capture = 1'b1;
          w_next    = S_REQ;
        end else begin
          ic_stall = 1'b0;
        end
      end
      S_REQ: begin
        ic_req = 1'b1;
        if (ic_req_ack) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (ic_rdat_m_valid) begin
          w_fill = 1'b1;
          w_next = S_FIN;
        end
      end
      // One extra stall cycle so the fetch RAM read sees the freshly written line
      S_FIN:   w_next = S_IDLE;
      S_FLUSH: if (r_cnt == IDX_W'(LINES - 1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      r_cnt        <= '0;
      r_line       <= '0;
      r_stall_dly  <= 1'b0;
      r_stall_fin2 <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_stall_dly  <= ic_stall;
      r_stall_fin2 <= ic_stall_fin;
      if (w_capture) r_line <= pc_if[31:4];
      if (w_fill) r_valid[r_line[IWIDTH+1:4]] <= 1'b1;
      if (r_state == S_FLUSH) begin
        r_valid[r_cnt] <= 1'b0;
        r_cnt          <= r_cnt + 1'b1;
      end
      // A flush arriving mid-fill is remembered and taken once the fill retires
      if (r_state == S_IDLE && w_next == S_FLUSH) begin
        r_flush_pend <= 1'b0;
      end else if (ic_flush && (r_state == S_REQ || r_state == S_WAIT || r_state == S_FIN)) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) r_tag[r_line[IWIDTH+1:4]] <= r_line[31:IWIDTH+2];
  end

  assign ic_req_adr      = r_line;
  assign ic_ram_wadr_all = r_line[IWIDTH+1:4];
  assign ic_stall_dly    = r_stall_dly;
  assign ic_stall_fin    = r_stall_dly & ~ic_stall;
  assign ic_stall_fin2   = r_stall_fin2;
  assign ic_flush_busy   = (r_state == S_FLUSH);

endmodule
